// File: rtl/dot_product_sequencer.sv
// Streams two operand vectors chunk by chunk from RAM into a dot-product datapath,
// masks the tail lanes beyond NOE, then waits (bounded) for the datapath result.
module dot_product_sequencer #(
  parameter int NOE     = 10,
  parameter int ELEM_W  = 32,
  parameter int UNITS   = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ELEM_W-1:0]       result,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [UNITS*ELEM_W-1:0] mem_a_data,
  input  logic [UNITS*ELEM_W-1:0] mem_b_data,
  output logic [UNITS*ELEM_W-1:0] dp_a,
  output logic [UNITS*ELEM_W-1:0] dp_b,
  output logic                    dp_valid,
  output logic                    dp_last,
  input  logic                    dp_finish,
  input  logic [ELEM_W-1:0]       dp_result,
  output logic [2:0]              dbg_state
);

  // Datapath handshake: dp_valid is a one-cycle qualifier with no back-pressure;
  // dp_a/dp_b are only meaningful while dp_valid is high and hold otherwise.
  localparam int CHUNKS = (NOE + UNITS - 1) / UNITS;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHUNKS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_DRAIN  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]       chunk_cnt;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    rd_pending;
  logic                    rd_last;
  logic [ADDR_W-1:0]       rd_chunk;
  logic [UNITS*ELEM_W-1:0] mask;
  logic                    timed_out;

  assign timed_out = (wait_cnt == WAIT_LAST);
  assign mem_addr  = chunk_cnt;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    mem_rd_en  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_STREAM;
      end
      S_STREAM: begin
        mem_rd_en = 1'b1;
        if (chunk_cnt == LAST_ADDR) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (dp_valid && dp_last) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (dp_finish || timed_out) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Lanes whose element index falls past NOE are zeroed; the chunk index
  // travels with the read so the mask lines up with the returning data.
  always_comb begin
    mask = '0;
    for (int i = 0; i < UNITS; i++) begin
      mask[i*ELEM_W +: ELEM_W] = ((int'(rd_chunk) * UNITS + i) < NOE) ? {ELEM_W{1'b1}} : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chunk_cnt  <= '0;
      wait_cnt   <= '0;
      rd_pending <= 1'b0;
      rd_last    <= 1'b0;
      rd_chunk   <= '0;
      dp_valid   <= 1'b0;
      dp_last    <= 1'b0;
      dp_a       <= '0;
      dp_b       <= '0;
      result     <= '0;
      error      <= 1'b0;
    end else begin
      if (state == S_IDLE && start) chunk_cnt <= '0;
      else if (state == S_STREAM && chunk_cnt != LAST_ADDR) chunk_cnt <= chunk_cnt + ADDR_W'(1);

      rd_pending <= mem_rd_en;
      rd_chunk   <= chunk_cnt;
      rd_last    <= (chunk_cnt == LAST_ADDR);

      dp_valid <= rd_pending;
      dp_last  <= rd_pending & rd_last;
      if (rd_pending) begin
        dp_a <= mem_a_data & mask;
        dp_b <= mem_b_data & mask;
      end

      if (state == S_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                 wait_cnt <= '0;

      if (state == S_IDLE && start) begin
        error <= 1'b0;
      end else if (state == S_WAIT) begin
        // A finish arriving on the last allowed cycle still counts as success.
        if (dp_finish) begin
          result <= dp_result;
        end else if (timed_out) begin
          result <= '0;
          error  <= 1'b1;
        end
      end
    end
  end

endmodule
